down_count_ctrl: RTL

Sequencing controller for the team's 4-bit down counter datapath. Accepts a load value over a valid/ready configuration handshake, then starts, pauses, aborts and optionally auto-reloads a down count. Counting advances on prescaled ticks, and the block issues a one-cycle `done` pulse at terminal count. It sits between a register/host interface and any logic that consumes `count`/`countbar`.

---
 rtl/down_count_pkg.sv | 14 +
 rtl/down_count_ctrl_tick_prescaler.sv | 29 ++
 rtl/down_count_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/down_count_pkg.sv
// Shared types and default sizes for the down-count sequencing controller.
package down_count_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PSC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

endpackage

// File: rtl/down_count_ctrl_tick_prescaler.sv
// Programmable tick divider: one tick every (period+1) enabled cycles, holds while disabled.
module tick_prescaler #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] period,
    output logic             tick
);

    logic [PSC_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit = (r_cnt == period);
    assign tick  = en & w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_count_ctrl.sv
// Sequencing controller for the 4-bit down counter: load handshake, start/pause/abort,
// prescaled decrement, optional auto-reload and a one-cycle done pulse at terminal count.
module down_count_ctrl
    import down_count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic             cfg_reload,
    input  logic [PSC_W-1:0] cfg_psc,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] countbar,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_val;
    logic             r_reload;
    logic [PSC_W-1:0] r_psc;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_xfer;
    logic             w_load;
    logic             w_tick;
    logic             w_presc_en;
    logic             w_presc_clr;

    assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_ARMED);
    assign busy      = (r_state == ST_RUN)  || (r_state == ST_PAUSED);
    assign count     = r_count;
    assign countbar  = ~r_count;
    assign done      = r_done;

    assign w_xfer = cfg_valid & cfg_ready;
    assign w_load = w_xfer & ~abort;

    // Prescaler only advances on cycles where pause is low, so pause time shifts
    // the tick schedule exactly cycle-for-cycle.
    assign w_presc_en  = busy & ~pause & ~abort;
    assign w_presc_clr = abort | ((r_state == ST_ARMED) & start & ~w_xfer);

    tick_prescaler #(
        .PSC_W(PSC_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (w_presc_en),
        .clr    (w_presc_clr),
        .period (r_psc),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_ARMED;
                        w_count_nxt = cfg_value;
                    end
                end
                ST_ARMED: begin
                    // A fresh configuration takes precedence over a coincident start.
                    if (w_xfer) begin
                        w_count_nxt = cfg_value;
                    end else if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_state_nxt = ST_RUN;
                        if (w_tick) begin
                            if (r_count != '0) begin
                                w_count_nxt = r_count - 1'b1;
                            end else begin
                                w_done_nxt = 1'b1;
                                if (r_reload) begin
                                    w_count_nxt = r_val;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                    w_count_nxt = '0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_val    <= '0;
            r_reload <= 1'b0;
            r_psc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_val    <= cfg_value;
                r_reload <= cfg_reload;
                r_psc    <= cfg_psc;
            end
        end
    end

endmodule
